sequence_step_scheduler: RTL and testbench

- Generates the step index and update strobe that drive the sequence BRAM reader, sequencing a table of steps in the ADC/DAC clock domain.
- Each step lasts a programmable number of samples. The table is repeated a programmable number of times, or forever.
- Started by an external trigger after arming. Status outputs feed the PS status register.

---
 rtl/sequence_step_scheduler.sv | 126 ++++++++++++
 tb/tb_sequence_step_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sequence_step_scheduler.sv
// Step sequencer for the sequence-table BRAM reader: walks step indices with a
// programmable dwell, repeats the table N times (or forever), armed then triggered.
module sequence_step_scheduler #(
   parameter int STEP_ADDR_WIDTH = 10,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       enable,
   input  logic                       trigger,
   input  logic [CNT_WIDTH-1:0]       cfg_samples_per_step,
   input  logic [STEP_ADDR_WIDTH:0]   cfg_num_steps,
   input  logic [CNT_WIDTH-1:0]       cfg_num_repetitions,
   output logic [STEP_ADDR_WIDTH-1:0] step_addr,
   output logic [STEP_ADDR_WIDTH-1:0] step_addr_next,
   output logic                       step_update,
   output logic                       sequence_active,
   output logic                       sequence_done,
   output logic                       armed,
   output logic [CNT_WIDTH-1:0]       repetition_count
);

   localparam logic [CNT_WIDTH-1:0]       CNT_ONE   = 1;
   localparam logic [STEP_ADDR_WIDTH:0]   STEPS_ONE = 1;
   localparam logic [STEP_ADDR_WIDTH-1:0] ADDR_ONE  = 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

   state_t                   state, state_nxt;
   logic                     trig_q, trig_edge;
   logic [CNT_WIDTH-1:0]     spp_l, reps_l, sample_cnt, rep_inc;
   logic [STEP_ADDR_WIDTH:0] steps_l;
   logic                     step_end, last_step, final_pass;
   logic                     latch_cfg, start_seq;

   assign trig_edge  = trigger & ~trig_q;
   assign step_end   = (sample_cnt == spp_l - CNT_ONE);
   assign last_step  = ({1'b0, step_addr} == steps_l - STEPS_ONE);
   assign rep_inc    = (repetition_count == '1) ? repetition_count : repetition_count + CNT_ONE;
   assign final_pass = (reps_l != '0) && (rep_inc == reps_l);

   // An empty table has no successor step, so next index reads 0 (also true out of reset).
   assign step_addr_next = (steps_l == '0 || last_step) ? '0 : step_addr + ADDR_ONE;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      latch_cfg       = 1'b0;
      start_seq       = 1'b0;
      sequence_active = (state == S_RUN);
      armed           = (state == S_ARMED);
      sequence_done   = (state == S_DONE);
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_ARMED;
               latch_cfg = 1'b1;
            end
            S_ARMED: begin
               if (trig_edge) begin
                  start_seq = 1'b1;
                  state_nxt = (steps_l == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (step_end && last_step && final_pass) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         trig_q           <= 1'b0;
         spp_l            <= '0;
         steps_l          <= '0;
         reps_l           <= '0;
         sample_cnt       <= '0;
         step_addr        <= '0;
         step_update      <= 1'b0;
         repetition_count <= '0;
      end else begin
         trig_q      <= trigger;
         step_update <= 1'b0;
         if (latch_cfg) begin
            spp_l   <= (cfg_samples_per_step == '0) ? CNT_ONE : cfg_samples_per_step;
            steps_l <= cfg_num_steps;
            reps_l  <= cfg_num_repetitions;
         end
         if (!enable) begin
            step_addr <= '0;
         end else if (start_seq) begin
            step_addr        <= '0;
            sample_cnt       <= '0;
            repetition_count <= '0;
            step_update      <= (steps_l != '0);
         end else if (state == S_RUN) begin
            if (step_end) begin
               sample_cnt <= '0;
               if (!last_step) begin
                  step_addr   <= step_addr + ADDR_ONE;
                  step_update <= 1'b1;
               end else begin
                  repetition_count <= rep_inc;
                  // On the final pass the last index is held through DONE.
                  if (!final_pass) begin
                     step_addr   <= '0;
                     step_update <= 1'b1;
                  end
               end
            end else begin
               sample_cnt <= sample_cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_sequence_step_scheduler.sv
// Scoreboard bench: stimulus pushes the step/done events a run should produce,
// a negedge monitor pops and compares them as the scheduler emits them.
module tb_sequence_step_scheduler;

   localparam int AW = 10;
   localparam int CW = 32;

   logic          aclk, aresetn, enable, trigger;
   logic [CW-1:0] cfg_samples_per_step, cfg_num_repetitions;
   logic [AW:0]   cfg_num_steps;
   logic [AW-1:0] step_addr, step_addr_next;
   logic          step_update, sequence_active, sequence_done, armed;
   logic [CW-1:0] repetition_count;

   sequence_step_scheduler #(.STEP_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .trigger(trigger),
      .cfg_samples_per_step(cfg_samples_per_step), .cfg_num_steps(cfg_num_steps),
      .cfg_num_repetitions(cfg_num_repetitions), .step_addr(step_addr),
      .step_addr_next(step_addr_next), .step_update(step_update),
      .sequence_active(sequence_active), .sequence_done(sequence_done),
      .armed(armed), .repetition_count(repetition_count)
   );

   typedef struct {
      bit is_done;
      int cyc;
      int addr;
      int nxt;
      int rep;
      bit chk_rep;
   } ev_t;

   ev_t sbq[$];
   ev_t mon_e;
   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   int  act_start = 0;
   int  act_end = 0;
   int  exp_addr = 0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   always @(negedge aclk) begin
      if (aresetn) begin
         check("active_window", longint'(sequence_active),
               longint'(cyc >= act_start && cyc < act_end));
         if (step_update || sequence_done) begin
            if (sbq.size() == 0) begin
               check("spurious_event", longint'({step_update, sequence_done}), 0);
            end else begin
               mon_e = sbq.pop_front();
               check("ev_done", longint'(sequence_done), longint'(mon_e.is_done));
               check("ev_update", longint'(step_update), longint'(!mon_e.is_done));
               check("ev_cycle", cyc, mon_e.cyc);
               check("ev_addr", longint'(step_addr), mon_e.addr);
               check("ev_addr_next", longint'(step_addr_next), mon_e.nxt);
               if (mon_e.chk_rep) check("ev_rep", longint'(repetition_count), mon_e.rep);
               exp_addr = mon_e.addr;
            end
         end else if (sequence_active) begin
            check("dwell_addr", longint'(step_addr), exp_addr);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_step_addr"}, longint'(step_addr), 0);
      check({tag, "_step_addr_next"}, longint'(step_addr_next), 0);
      check({tag, "_step_update"}, longint'(step_update), 0);
      check({tag, "_active"}, longint'(sequence_active), 0);
      check({tag, "_done"}, longint'(sequence_done), 0);
      check({tag, "_armed"}, longint'(armed), 0);
      check({tag, "_rep"}, longint'(repetition_count), 0);
   endtask

   // One armed/triggered run. Expected events follow from the rules directly:
   // global step n starts at s + n*spp, index n%steps, pass n/steps.
   task automatic run_seq(input int spp, input int steps, input int reps,
                          input int abort_after, input int rst_after,
                          input bit cfg_change, input bit trig_pre);
      int  spp_e, s, total, limit;
      ev_t ev;
      spp_e = (spp == 0) ? 1 : spp;
      enable = 1'b0;
      trigger = trig_pre;
      tick(2);
      cfg_samples_per_step = CW'(spp);
      cfg_num_steps        = (AW+1)'(steps);
      cfg_num_repetitions  = CW'(reps);
      enable = 1'b1;
      tick(1);
      check("armed_after_enable", longint'(armed), 1);
      cfg_samples_per_step = CW'($urandom_range(1, 9));
      cfg_num_repetitions  = CW'($urandom_range(1, 5));
      if (trig_pre) begin
         tick(3);
         check("held_trigger_no_start", longint'(sequence_active), 0);
         check("held_trigger_still_armed", longint'(armed), 1);
         trigger = 1'b0;
         tick(1);
      end
      trigger = 1'b1;
      s     = cyc + 1;
      total = reps * steps * spp_e;
      if (abort_after > 0)    limit = abort_after;
      else if (rst_after > 0) limit = rst_after - 1;
      else                    limit = total + 1;
      for (int n = 0; steps > 0 && (reps == 0 || n < reps * steps) && n * spp_e < limit; n++) begin
         ev.is_done = 1'b0;
         ev.cyc     = s + n * spp_e;
         ev.addr    = n % steps;
         ev.nxt     = (n % steps == steps - 1) ? 0 : n % steps + 1;
         ev.rep     = n / steps;
         ev.chk_rep = 1'b1;
         sbq.push_back(ev);
      end
      if (steps == 0 || (reps != 0 && abort_after == 0 && rst_after == 0)) begin
         ev.is_done = 1'b1;
         ev.cyc     = s + total;
         ev.addr    = (steps == 0) ? 0 : steps - 1;
         ev.nxt     = 0;
         ev.rep     = reps;
         ev.chk_rep = (steps > 0);
         sbq.push_back(ev);
      end
      act_start = s;
      if (steps == 0)         act_end = s;
      else if (abort_after>0) act_end = s + abort_after;
      else if (rst_after > 0) act_end = s + rst_after - 1;
      else                    act_end = s + total;
      tick(1);
      trigger = 1'b0;
      if (cfg_change) cfg_num_steps = (AW+1)'(7);
      if (abort_after > 0) begin
         while (cyc < s + abort_after - 1) tick(1);
         enable = 1'b0;
         tick(1);
         check("abort_step_addr", longint'(step_addr), 0);
         check("abort_active", longint'(sequence_active), 0);
         check("abort_armed", longint'(armed), 0);
         check("abort_rep_held", longint'(repetition_count), (abort_after - 1) / (steps * spp_e));
         tick(3);
      end else if (rst_after > 0) begin
         while (cyc < s + rst_after - 1) tick(1);
         #2;
         sbq.delete();
         aresetn = 1'b0;
         #1;
         check_all_zero("async_reset");
         @(posedge aclk);
         #3;
         aresetn = 1'b1;
         #1;
         check("post_reset_armed", longint'(armed), 0);
         check("post_reset_active", longint'(sequence_active), 0);
      end else begin
         while (cyc < s + total + 2) tick(1);
         check("auto_rearm", longint'(armed), 1);
         if (steps > 0) check("final_rep", longint'(repetition_count), reps);
      end
      check("scoreboard_drained", sbq.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      aresetn = 1'b0;
      enable  = 1'b0;
      trigger = 1'b0;
      cfg_samples_per_step = '0;
      cfg_num_steps        = '0;
      cfg_num_repetitions  = '0;
      #2;
      check_all_zero("reset");
      #10;
      aresetn = 1'b1;
      tick(2);
      run_seq(4, 3, 2, 0, 0, 1'b0, 1'b0);
      run_seq(0, 5, 1, 0, 0, 1'b0, 1'b0);
      run_seq(3, 0, 2, 0, 0, 1'b0, 1'b0);
      run_seq(3, 2, 0, 20, 0, 1'b0, 1'b0);
      run_seq(2, 3, 2, 0, 0, 1'b1, 1'b0);
      run_seq(2, 2, 1, 0, 0, 1'b0, 1'b1);
      run_seq(1, 1, 3, 0, 0, 1'b0, 1'b0);
      run_seq(4, 3, 0, 0, 7, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         run_seq($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 3),
                 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run_seq(1, 3, 0, 13, 0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
